// File: rtl/ysyx_210544_cache_nocache_arb.sv
// Round-robin arbiter that puts NCH uncached requesters onto one AXI io port.
// Aligned accesses go out as one beat; misaligned/odd sizes become byte beats and are reassembled.
module ysyx_210544_cache_nocache_arb #(
    parameter int NCH      = 2,
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    i_req,
    input  logic [NCH-1:0]    i_op,
    input  logic [NCH*64-1:0] i_addr,
    input  logic [NCH*64-1:0] i_wdata,
    input  logic [NCH*3-1:0]  i_bytes,
    output logic [NCH*64-1:0] o_rdata,
    output logic [NCH-1:0]    o_ack,
    input  logic [511:0]      i_axi_io_rdata,
    input  logic              i_axi_io_ready,
    output logic              o_axi_io_valid,
    output logic              o_axi_io_op,
    output logic [511:0]      o_axi_io_wdata,
    output logic [63:0]       o_axi_io_addr,
    output logic [2:0]        o_axi_io_size,
    output logic [7:0]        o_axi_io_blks
);
    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_ACK   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [GW-1:0]     last_q, last_d;
    logic [GW-1:0]     gnt_q, gnt_d;
    logic [63:0]       addr_q, addr_d;
    logic              op_q, op_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [2:0]        size_q, size_d;
    logic [3:0]        beats_q, beats_d;
    logic [2:0]        k_q, k_d;
    logic [63:0]       res_q, res_d;
    logic [NCH*64-1:0] rdata_q, rdata_d;

    logic              found;
    logic [GW-1:0]     sel;
    logic [63:0]       sel_addr;
    logic [2:0]        sel_bytes;
    logic [3:0]        sel_n;
    logic              sel_aligned;
    logic [2:0]        sel_size;
    logic [63:0]       beat_mask;
    logic              unused_rdata_hi;

    assign unused_rdata_hi = ^i_axi_io_rdata[511:64];

    // First requester at or after last+1, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = last_q;
        for (int i = 1; i <= NCH; i++) begin
            if (!found && i_req[(int'(last_q) + i) % NCH]) begin
                found = 1'b1;
                sel   = GW'((int'(last_q) + i) % NCH);
            end
        end
    end

    always_comb begin
        sel_addr    = i_addr[sel*64 +: 64];
        sel_bytes   = i_bytes[sel*3 +: 3];
        sel_n       = {1'b0, sel_bytes} + 4'd1;
        // For power-of-two n, bytes == n-1 doubles as the alignment mask.
        sel_aligned = ((sel_n == 4'd1) || (sel_n == 4'd2) || (sel_n == 4'd4) || (sel_n == 4'd8))
                      && ((sel_addr[2:0] & sel_bytes) == 3'd0);
        case (sel_n)
            4'd2:    sel_size = 3'd1;
            4'd4:    sel_size = 3'd2;
            4'd8:    sel_size = 3'd3;
            default: sel_size = 3'd0;
        endcase
        case (size_q)
            3'd0:    beat_mask = 64'h0000_0000_0000_00FF;
            3'd1:    beat_mask = 64'h0000_0000_0000_FFFF;
            3'd2:    beat_mask = 64'h0000_0000_FFFF_FFFF;
            default: beat_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        op_d    = op_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        beats_d = beats_q;
        k_d     = k_q;
        res_d   = res_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    gnt_d   = sel;
                    addr_d  = sel_addr;
                    op_d    = i_op[sel];
                    wdata_d = i_wdata[sel*64 +: 64];
                    k_d     = 3'd0;
                    res_d   = 64'd0;
                    if (sel_aligned || !SPLIT_EN) begin
                        beats_d = 4'd1;
                        size_d  = sel_aligned ? sel_size : 3'd0;
                    end else begin
                        beats_d = sel_n;
                        size_d  = 3'd0;
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (i_axi_io_ready) begin
                    if (!op_q) begin
                        if (beats_q == 4'd1) begin
                            res_d = i_axi_io_rdata[63:0] & beat_mask;
                        end else begin
                            res_d[{k_q, 3'b000} +: 8] = i_axi_io_rdata[7:0];
                        end
                    end
                    if ({1'b0, k_q} == beats_q - 4'd1) begin
                        // Publish read data now so it is valid alongside the ack pulse.
                        if (!op_q) begin
                            rdata_d[gnt_q*64 +: 64] = res_d;
                        end
                        state_d = S_ACK;
                    end else begin
                        k_d     = k_q + 3'd1;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                state_d = S_ISSUE;
            end
            default: begin
                last_d  = gnt_q;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            last_q  <= GW'(NCH - 1);
            gnt_q   <= '0;
            addr_q  <= 64'd0;
            op_q    <= 1'b0;
            wdata_q <= 64'd0;
            size_q  <= 3'd0;
            beats_q <= 4'd1;
            k_q     <= 3'd0;
            res_q   <= 64'd0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            beats_q <= beats_d;
            k_q     <= k_d;
            res_q   <= res_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        o_ack = '0;
        if (state_q == S_ACK) begin
            o_ack[gnt_q] = 1'b1;
        end
    end

    assign o_rdata        = rdata_q;
    assign o_axi_io_valid = (state_q == S_ISSUE);
    assign o_axi_io_op    = op_q;
    assign o_axi_io_addr  = addr_q + {61'd0, k_q};
    assign o_axi_io_wdata = {448'd0, wdata_q >> {k_q, 3'b000}};
    assign o_axi_io_size  = size_q;
    assign o_axi_io_blks  = 8'd0;
endmodule

// File: tb/tb_ysyx_210544_cache_nocache_arb.sv
// Randomised bench: io slave with byte-addressed memory, per-ack transaction scoreboard.
module tb_ysyx_210544_cache_nocache_arb;
    localparam int NCH = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    i_req, i_op;
    logic [NCH*64-1:0] i_addr, i_wdata;
    logic [NCH*3-1:0]  i_bytes;
    logic [NCH*64-1:0] o_rdata;
    logic [NCH-1:0]    o_ack;
    logic [511:0]      i_axi_io_rdata;
    logic              i_axi_io_ready;
    logic              o_axi_io_valid, o_axi_io_op;
    logic [511:0]      o_axi_io_wdata;
    logic [63:0]       o_axi_io_addr;
    logic [2:0]        o_axi_io_size;
    logic [7:0]        o_axi_io_blks;

    ysyx_210544_cache_nocache_arb #(.NCH(NCH), .SPLIT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .i_req(i_req), .i_op(i_op), .i_addr(i_addr),
        .i_wdata(i_wdata), .i_bytes(i_bytes), .o_rdata(o_rdata), .o_ack(o_ack),
        .i_axi_io_rdata(i_axi_io_rdata), .i_axi_io_ready(i_axi_io_ready),
        .o_axi_io_valid(o_axi_io_valid), .o_axi_io_op(o_axi_io_op),
        .o_axi_io_wdata(o_axi_io_wdata), .o_axi_io_addr(o_axi_io_addr),
        .o_axi_io_size(o_axi_io_size), .o_axi_io_blks(o_axi_io_blks)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [2:0]  size;
        logic        op;
        logic [63:0] wdata;
        logic        whi;
        logic [7:0]  blks;
        int          start_c;
        int          ready_c;
    } txn_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    txn_t        log_q[$];
    int          ack_order[$];
    logic [7:0]  ovr [logic [63:0]];
    logic [63:0] exp_rd [NCH];
    int          n_req [NCH];
    int          n_ack [NCH];
    int          stall = 0;
    int          fixw  = -1;
    int          maxw  = 2;
    int          wcnt  = -1;
    int          st_c  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] memb(input logic [63:0] a);
        logic [63:0] h;
        if (ovr.exists(a)) return ovr[a];
        h = a * 64'd37 + (a >> 5) + 64'h5A;
        return h[7:0];
    endfunction

    function automatic logic [63:0] mem8(input logic [63:0] a);
        logic [63:0] v;
        v = 64'd0;
        for (int i = 0; i < 8; i++) v[i*8 +: 8] = memb(a + 64'(i));
        return v;
    endfunction

    // Reference: what the io port must have seen for the request of channel c.
    task automatic check_ack();
        int          c;
        int          n;
        int          beats;
        bit          aligned;
        logic [2:0]  sz;
        logic [63:0] base, wd, m, ev;
        logic        op;
        chk("ack_onehot", 64'($countones(o_ack)), 64'd1);
        chk("vld_in_ack", 64'(o_axi_io_valid), 64'd0);
        c = o_ack[1] ? 1 : 0;
        base    = i_addr[c*64 +: 64];
        wd      = i_wdata[c*64 +: 64];
        op      = i_op[c];
        n       = int'(i_bytes[c*3 +: 3]) + 1;
        aligned = (n == 1 || n == 2 || n == 4 || n == 8) && (base % 64'(n) == 0);
        beats   = aligned ? 1 : n;
        sz      = aligned ? 3'($clog2(n)) : 3'd0;
        chk("beats", 64'(log_q.size()), 64'(beats));
        for (int k = 0; k < beats && k < log_q.size(); k++) begin
            chk("addr", log_q[k].addr, base + 64'(k));
            chk("size", 64'(log_q[k].size), 64'(sz));
            chk("op", 64'(log_q[k].op), 64'(op));
            chk("blks", 64'(log_q[k].blks), 64'd0);
            chk("wdat_hi", 64'(log_q[k].whi), 64'd0);
            if (op) begin
                m = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 64'd1);
                if (aligned) chk("wdat", log_q[k].wdata & m, wd & m);
                else         chk("wdat_b", 64'(log_q[k].wdata[7:0]), (wd >> (8 * k)) & 64'hFF);
            end
            if (k > 0) chk("gap", 64'(log_q[k].start_c), 64'(log_q[k-1].ready_c + 2));
        end
        if (log_q.size() > 0) chk("ack_lat", 64'(cyc), 64'(log_q[log_q.size()-1].ready_c + 1));
        if (!op) begin
            ev = 64'd0;
            for (int i = 0; i < n; i++) ev[i*8 +: 8] = memb(base + 64'(i));
            exp_rd[c] = ev;
        end
        for (int j = 0; j < NCH; j++) chk("rdata", o_rdata[j*64 +: 64], exp_rd[j]);
        log_q.delete();
        n_ack[c]++;
        ack_order.push_back(c);
    endtask

    // io slave and ack monitor share one process so their ordering is fixed.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            i_axi_io_ready = 1'b0;
            if (rst) begin
                wcnt = -1;
                continue;
            end
            if (o_ack != '0) check_ack();
            if (o_axi_io_valid) begin
                if (wcnt < 0) begin
                    st_c = cyc;
                    wcnt = (fixw >= 0) ? fixw : int'($urandom_range(0, maxw));
                end
                if (stall == 0 && wcnt == 0) begin
                    i_axi_io_ready = 1'b1;
                    i_axi_io_rdata = {{14{32'($urandom)}}, mem8(o_axi_io_addr)};
                    log_q.push_back('{o_axi_io_addr, o_axi_io_size, o_axi_io_op,
                                      o_axi_io_wdata[63:0], |o_axi_io_wdata[511:64],
                                      o_axi_io_blks, st_c, cyc});
                    wcnt = -1;
                end else if (wcnt > 0) begin
                    wcnt--;
                end
            end
        end
    end

    task automatic issue(input int c, input logic op, input logic [63:0] a,
                         input logic [63:0] wd, input logic [2:0] b);
        i_op[c]          = op;
        i_addr[c*64 +: 64]  = a;
        i_wdata[c*64 +: 64] = wd;
        i_bytes[c*3 +: 3]   = b;
        i_req[c]         = 1'b1;
        n_req[c]++;
    endtask

    task automatic wait_ack(input int c);
        int t;
        for (t = 0; t < 300; t++) begin
            @(posedge clk);
            #1;
            if (o_ack[c]) break;
        end
        if (t >= 300) chk("ack_timeout", 64'(o_ack[c]), 64'd1);
        i_req[c] = 1'b0;
    endtask

    task automatic drive(input int c, input int nr);
        logic [63:0] a;
        for (int r = 0; r < nr; r++) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            a = {32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 7) == 0) a = 64'hFFFF_FFFF_FFFF_FFF8 | 64'($urandom_range(0, 7));
            issue(c, 1'($urandom_range(0, 1)), a, {32'($urandom), 32'($urandom)},
                  3'($urandom_range(0, 7)));
            wait_ack(c);
        end
    endtask

    initial begin
        logic [63:0] v;
        i_req = '0; i_op = '0; i_addr = '0; i_wdata = '0; i_bytes = '0;
        i_axi_io_rdata = '0; i_axi_io_ready = 1'b0;
        for (int j = 0; j < NCH; j++) begin exp_rd[j] = 64'd0; n_req[j] = 0; n_ack[j] = 0; end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld", 64'(o_axi_io_valid), 64'd0);
        chk("rst_op", 64'(o_axi_io_op), 64'd0);
        chk("rst_addr", o_axi_io_addr, 64'd0);
        chk("rst_wdat", 64'(|o_axi_io_wdata), 64'd0);
        chk("rst_size", 64'(o_axi_io_size), 64'd0);
        chk("rst_blks", 64'(o_axi_io_blks), 64'd0);
        chk("rst_ack", 64'(o_ack), 64'd0);
        chk("rst_rdata", 64'(|o_rdata), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Aligned 8-byte read, ready after three wait cycles.
        v = 64'h1122_3344_5566_7788;
        for (int i = 0; i < 8; i++) ovr[64'h1000_0008 + 64'(i)] = v[i*8 +: 8];
        fixw = 3;
        @(negedge clk);
        issue(0, 1'b0, 64'h1000_0008, 64'd0, 3'd7);
        wait_ack(0);
        chk("t1_rdata", o_rdata[63:0], 64'h1122_3344_5566_7788);
        fixw = -1;

        // Misaligned halfword write -> two byte beats.
        @(negedge clk);
        issue(1, 1'b1, 64'h1000_0001, 64'hBEEF, 3'd1);
        wait_ack(1);

        // Split 4-byte read at ...3.
        ovr[64'h2000_0003] = 8'h44; ovr[64'h2000_0004] = 8'h33;
        ovr[64'h2000_0005] = 8'h22; ovr[64'h2000_0006] = 8'h11;
        @(negedge clk);
        issue(0, 1'b0, 64'h2000_0003, 64'd0, 3'd3);
        wait_ack(0);
        chk("t3_rdata", o_rdata[63:0], 64'h0000_0000_1122_3344);

        // Aligned halfword read; neighbouring bytes are nonzero.
        for (int i = 2; i < 8; i++) ovr[64'h4000_0006 + 64'(i)] = 8'hFF;
        @(negedge clk);
        issue(1, 1'b0, 64'h4000_0006, 64'd0, 3'd1);
        wait_ack(1);
        chk("t5_hi_zero", {16'd0, o_rdata[127:80]}, 64'd0);

        // Reset while a transaction is on the bus.
        stall = 1;
        @(negedge clk);
        issue(0, 1'b0, 64'h3000_0000, 64'd0, 3'd7);
        for (int t = 0; t < 50; t++) begin
            @(posedge clk);
            #1;
            if (o_axi_io_valid) break;
        end
        chk("rst_vld_seen", 64'(o_axi_io_valid), 64'd1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_vld_drop", 64'(o_axi_io_valid), 64'd0);
        chk("rst_no_ack", 64'(o_ack), 64'd0);
        i_req = '0;
        n_req[0]--;
        @(negedge clk);
        rst = 1'b0;
        log_q.delete();
        for (int j = 0; j < NCH; j++) exp_rd[j] = 64'd0;
        stall = 0;
        chk("rst_rdata_clr", 64'(|o_rdata), 64'd0);

        // Simultaneous requests from reset: expect 0,1,0,1.
        ack_order.delete();
        @(negedge clk);
        issue(0, 1'b0, 64'h5000_0000, 64'd0, 3'd3);
        issue(1, 1'b1, 64'h5000_0011, 64'h1234, 3'd2);
        fork
            begin
                wait_ack(0);
                @(negedge clk);
                issue(0, 1'b1, 64'h5000_0020, 64'hA5A5, 3'd1);
                wait_ack(0);
            end
            begin
                wait_ack(1);
                @(negedge clk);
                issue(1, 1'b0, 64'h5000_0031, 64'd0, 3'd0);
                wait_ack(1);
            end
        join
        chk("rr_count", 64'(ack_order.size()), 64'd4);
        for (int i = 0; i < ack_order.size() && i < 4; i++) chk("rr_order", 64'(ack_order[i]), 64'(i % 2));

        // Random traffic on both channels.
        maxw = 3;
        fork
            drive(0, 40);
            drive(1, 40);
        join
        repeat (5) @(posedge clk);
        #1;
        for (int j = 0; j < NCH; j++) chk("ack_count", 64'(n_ack[j]), 64'(n_req[j]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
